// File: rtl/muxf_pipe.sv
// muxf_pipe: parameterised N:1 mux built as a binary tree of 2:1 levels,
// with either a single output register or a register after every level.
//
// Ports
//   C      clock, rising edge
//   CLR    asynchronous active-high clear of all state
//   CE     clock enable; low holds every register
//   I      flat data bus, input k at [k*WIDTH +: WIDTH]
//   I_VLD  sample qualifier, delayed alongside the data to O_VLD
//   S      select (direct mode) or lock-register load value (lock mode)
//   S_LD   load S into the lock register (lock mode only)
//   O, LO  selected data (LO is the same register as O)
//   O_VLD  O/LO carry a valid result
//   S_CUR  lock register contents, 0 in direct mode
module muxf_pipe #(
    parameter int unsigned WIDTH     = 1,
    parameter int unsigned SEL_WIDTH = 3,
    parameter int unsigned PIPE_ALL  = 0,
    parameter int unsigned LOCK_SEL  = 0
) (
    input  logic                                C,
    input  logic                                CLR,
    input  logic                                CE,
    input  logic [(1<<SEL_WIDTH)*WIDTH-1:0]     I,
    input  logic                                I_VLD,
    input  logic [SEL_WIDTH-1:0]                S,
    input  logic                                S_LD,
    output logic [WIDTH-1:0]                    O,
    output logic [WIDTH-1:0]                    LO,
    output logic                                O_VLD,
    output logic [SEL_WIDTH-1:0]                S_CUR
);

    localparam int unsigned N   = 1 << SEL_WIDTH;
    localparam int unsigned LAT = (PIPE_ALL != 0) ? SEL_WIDTH : 1;

    logic [SEL_WIDTH-1:0] se_c;

    // Effective select: direct S, or lock register with same-cycle load bypass
    if (LOCK_SEL != 0) begin : g_lock
        logic [SEL_WIDTH-1:0] lock_q;

        always_ff @(posedge C or posedge CLR) begin
            if (CLR) begin
                lock_q <= '0;
            end else if (CE && S_LD) begin
                lock_q <= S;
            end
        end

        assign se_c  = S_LD ? S : lock_q;
        assign S_CUR = lock_q;
    end else begin : g_direct
        logic unused_s_ld;
        assign unused_s_ld = S_LD;
        assign se_c        = S;
        assign S_CUR       = '0;
    end

    // Tree levels: level j halves the candidate set using select bit j.
    // Remaining select bits ride along with the data so a pipelined level
    // never looks back at S.
    for (genvar j = 0; j < int'(SEL_WIDTH); j++) begin : g_lvl
        localparam int unsigned NI  = N >> j;
        localparam int unsigned NO  = NI >> 1;
        localparam int unsigned SWI = SEL_WIDTH - j;

        logic [NI*WIDTH-1:0] d_in;
        logic [SWI-1:0]      s_in;
        logic [NO*WIDTH-1:0] d_mux_c;

        if (j == 0) begin : g_first
            assign d_in = I;
            assign s_in = se_c;
        end else begin : g_next
            assign d_in = g_lvl[j-1].g_mid.d_out;
            assign s_in = g_lvl[j-1].g_mid.s_out;
        end

        always_comb begin
            d_mux_c = '0;
            for (int unsigned k = 0; k < NO; k++) begin
                d_mux_c[k*WIDTH +: WIDTH] = s_in[0] ? d_in[(2*k+1)*WIDTH +: WIDTH]
                                                    : d_in[(2*k)*WIDTH +: WIDTH];
            end
        end

        // Hand-off to the next level; the last level feeds the output register
        if (j < int'(SEL_WIDTH) - 1) begin : g_mid
            logic [NO*WIDTH-1:0] d_out;
            logic [SWI-2:0]      s_out;

            if (PIPE_ALL != 0) begin : g_reg
                logic [NO*WIDTH-1:0] d_q;
                logic [SWI-2:0]      s_q;

                always_ff @(posedge C or posedge CLR) begin
                    if (CLR) begin
                        d_q <= '0;
                        s_q <= '0;
                    end else if (CE) begin
                        d_q <= d_mux_c;
                        s_q <= s_in[SWI-1:1];
                    end
                end

                assign d_out = d_q;
                assign s_out = s_q;
            end else begin : g_comb
                assign d_out = d_mux_c;
                assign s_out = s_in[SWI-1:1];
            end
        end
    end

    // Output register, shared by O and LO so they can never diverge
    logic [WIDTH-1:0] o_q;

    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            o_q <= '0;
        end else if (CE) begin
            o_q <= g_lvl[SEL_WIDTH-1].d_mux_c;
        end
    end

    assign O  = o_q;
    assign LO = o_q;

    // Valid shift register, same depth and enable as the data path
    logic [LAT-1:0] vld_q;

    if (LAT == 1) begin : g_vld1
        always_ff @(posedge C or posedge CLR) begin
            if (CLR) begin
                vld_q <= '0;
            end else if (CE) begin
                vld_q <= I_VLD;
            end
        end
    end else begin : g_vldn
        always_ff @(posedge C or posedge CLR) begin
            if (CLR) begin
                vld_q <= '0;
            end else if (CE) begin
                vld_q <= {vld_q[LAT-2:0], I_VLD};
            end
        end
    end

    assign O_VLD = vld_q[LAT-1];

endmodule

// File: tb/tb_muxf_pipe.sv
// Scoreboard bench for muxf_pipe: two instances share stimulus.
//   dut_a: WIDTH=4, SEL_WIDTH=3, PIPE_ALL=1, LOCK_SEL=1 (latency 3)
//   dut_b: WIDTH=4, SEL_WIDTH=3, PIPE_ALL=0, LOCK_SEL=0 (latency 1)
// Stimulus pushes {valid, data} per enabled edge; the monitor pops one entry
// per enabled edge and checks O, LO, O_VLD, S_CUR, and freezing when CE=0.
module tb_muxf_pipe;

    logic        clk;
    logic        clr;
    logic        ce;
    logic [31:0] i_data;
    logic        i_vld;
    logic [2:0]  s;
    logic        s_ld;

    logic [3:0]  o_a, lo_a, o_b, lo_b;
    logic        o_vld_a, o_vld_b;
    logic [2:0]  s_cur_a, s_cur_b;

    int n_tests = 0;
    int n_fail  = 0;

    logic [4:0]  q_a[$];
    logic [4:0]  q_b[$];
    logic [2:0]  lock_m;
    logic [3:0]  prev_o_a, prev_o_b;
    logic        prev_v_a, prev_v_b;

    muxf_pipe #(.WIDTH(4), .SEL_WIDTH(3), .PIPE_ALL(1), .LOCK_SEL(1)) dut_a (
        .C(clk), .CLR(clr), .CE(ce), .I(i_data), .I_VLD(i_vld), .S(s), .S_LD(s_ld),
        .O(o_a), .LO(lo_a), .O_VLD(o_vld_a), .S_CUR(s_cur_a)
    );

    muxf_pipe #(.WIDTH(4), .SEL_WIDTH(3), .PIPE_ALL(0), .LOCK_SEL(0)) dut_b (
        .C(clk), .CLR(clr), .CE(ce), .I(i_data), .I_VLD(i_vld), .S(s), .S_LD(s_ld),
        .O(o_b), .LO(lo_b), .O_VLD(o_vld_b), .S_CUR(s_cur_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state after a clear: pipeline full of zero, invalid entries
    task automatic model_reset();
        q_a.delete();
        q_b.delete();
        q_a.push_back(5'd0);
        q_a.push_back(5'd0);
        lock_m   = 3'd0;
        prev_o_a = 4'd0;
        prev_o_b = 4'd0;
        prev_v_a = 1'b0;
        prev_v_b = 1'b0;
    endtask

    // Drive one cycle of stimulus and record the expected result
    task automatic step(input logic [31:0] iv, input logic [2:0] sv, input logic vld,
                        input logic cev, input logic sld);
        logic [2:0] se_a;
        @(negedge clk);
        i_data = iv;
        s      = sv;
        i_vld  = vld;
        ce     = cev;
        s_ld   = sld;
        if (cev) begin
            se_a = sld ? sv : lock_m;
            q_a.push_back({vld, iv[se_a*4 +: 4]});
            q_b.push_back({vld, iv[sv*4 +: 4]});
            if (sld) lock_m = sv;
        end
    endtask

    // Asynchronous clear pulse between clock edges
    task automatic clr_pulse();
        @(negedge clk);
        #2 clr = 1'b1;
        #1;
        check("clr_o_a",    32'(o_a),     32'd0);
        check("clr_lo_a",   32'(lo_a),    32'd0);
        check("clr_vld_a",  32'(o_vld_a), 32'd0);
        check("clr_scur_a", 32'(s_cur_a), 32'd0);
        check("clr_o_b",    32'(o_b),     32'd0);
        check("clr_vld_b",  32'(o_vld_b), 32'd0);
        #1 clr = 1'b0;
        ce    = 1'b0;
        i_vld = 1'b0;
        s_ld  = 1'b0;
        model_reset();
    endtask

    // Monitor: one scoreboard pop per enabled edge, freeze check otherwise
    always @(posedge clk) begin
        logic       ce_s;
        logic [4:0] e;
        ce_s = ce;
        #1;
        if (!clr) begin
            if (ce_s) begin
                if (q_a.size() == 0) begin
                    check("a_underflow", 32'(q_a.size()), 32'd1);
                end else begin
                    e = q_a.pop_front();
                    check("a_o",   32'(o_a),     32'(e[3:0]));
                    check("a_vld", 32'(o_vld_a), 32'(e[4]));
                end
                if (q_b.size() == 0) begin
                    check("b_underflow", 32'(q_b.size()), 32'd1);
                end else begin
                    e = q_b.pop_front();
                    check("b_o",   32'(o_b),     32'(e[3:0]));
                    check("b_vld", 32'(o_vld_b), 32'(e[4]));
                end
            end else begin
                check("a_hold_o",   32'(o_a),     32'(prev_o_a));
                check("a_hold_vld", 32'(o_vld_a), 32'(prev_v_a));
                check("b_hold_o",   32'(o_b),     32'(prev_o_b));
                check("b_hold_vld", 32'(o_vld_b), 32'(prev_v_b));
            end
            check("a_lo_eq_o", 32'(lo_a),    32'(o_a));
            check("b_lo_eq_o", 32'(lo_b),    32'(o_b));
            check("a_scur",    32'(s_cur_a), 32'(lock_m));
            check("b_scur",    32'(s_cur_b), 32'd0);
            prev_o_a = o_a;
            prev_o_b = o_b;
            prev_v_a = o_vld_a;
            prev_v_b = o_vld_b;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        clr    = 1'b1;
        ce     = 1'b0;
        i_data = 32'h0;
        i_vld  = 1'b0;
        s      = 3'd0;
        s_ld   = 1'b0;
        model_reset();

        repeat (2) @(negedge clk);
        check("rst_o_a",    32'(o_a),     32'd0);
        check("rst_lo_a",   32'(lo_a),    32'd0);
        check("rst_vld_a",  32'(o_vld_a), 32'd0);
        check("rst_scur_a", 32'(s_cur_a), 32'd0);
        check("rst_o_b",    32'(o_b),     32'd0);
        check("rst_vld_b",  32'(o_vld_b), 32'd0);
        clr = 1'b0;

        // Single sample, select 5, then stepping selects 0..7
        step(32'h7654_3210, 3'd5, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 8; k++) step(32'h7654_3210, 3'(k), 1'b1, 1'b1, 1'b1);

        // Mid-stream CE=0 for two cycles (S_LD/I_VLD must be ignored)
        step(32'hFEDC_BA98, 3'd1, 1'b1, 1'b1, 1'b1);
        step(32'hFEDC_BA98, 3'd2, 1'b1, 1'b1, 1'b1);
        step(32'h0000_0000, 3'd7, 1'b1, 1'b0, 1'b1);
        step(32'h0000_0000, 3'd3, 1'b0, 1'b0, 1'b1);
        step(32'hFEDC_BA98, 3'd3, 1'b1, 1'b1, 1'b1);
        step(32'hFEDC_BA98, 3'd4, 1'b1, 1'b1, 1'b1);

        // Lock 6, then S wanders with S_LD=0
        step(32'h3C5A_9F17, 3'd6, 1'b1, 1'b1, 1'b1);
        step(32'h3C5A_9F17, 3'd0, 1'b1, 1'b1, 1'b0);
        step(32'hA1B2_C3D4, 3'd3, 1'b1, 1'b1, 1'b0);
        step(32'h1234_5678, 3'd7, 1'b1, 1'b1, 1'b0);
        step(32'h8765_4321, 3'd1, 1'b1, 1'b0, 1'b0);
        step(32'h8765_4321, 3'd2, 1'b1, 1'b1, 1'b0);

        // Alternating I_VLD, back-to-back differing selects
        step(32'h0F1E_2D3C, 3'd0, 1'b1, 1'b1, 1'b1);
        step(32'h4B5A_6978, 3'd7, 1'b0, 1'b1, 1'b1);
        step(32'h8796_A5B4, 3'd2, 1'b1, 1'b1, 1'b1);
        step(32'hC3D2_E1F0, 3'd5, 1'b0, 1'b1, 1'b1);
        step(32'h1357_9BDF, 3'd4, 1'b1, 1'b1, 1'b1);

        // Three valid samples in flight, then asynchronous clear
        step(32'h7654_3210, 3'd1, 1'b1, 1'b1, 1'b1);
        step(32'h7654_3210, 3'd2, 1'b1, 1'b1, 1'b1);
        step(32'h7654_3210, 3'd3, 1'b1, 1'b1, 1'b1);
        clr_pulse();
        step(32'h7654_3210, 3'd4, 1'b0, 1'b1, 1'b0);
        step(32'h7654_3210, 3'd5, 1'b0, 1'b1, 1'b0);
        step(32'hEDCB_A987, 3'd6, 1'b1, 1'b1, 1'b1);
        step(32'hEDCB_A987, 3'd0, 1'b0, 1'b1, 1'b0);
        step(32'hEDCB_A987, 3'd0, 1'b0, 1'b1, 1'b0);

        // Mixed enables, selects, loads and valids
        for (int k = 0; k < 64; k++) begin
            step($urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        end

        // Drain
        for (int k = 0; k < 4; k++) step(32'h0, 3'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        ce = 1'b0;
        @(posedge clk);
        #2;
        check("a_queue_left", 32'(q_a.size()), 32'd2);
        check("b_queue_left", 32'(q_b.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
